// File: rtl/packet_receive_buffer.sv
// Purpose : reassemble HEAD..BODY..TAIL flits into one packet_element_t and hold it until acked.
// Latency : TAIL accepted at edge N -> received_packet_valid high just after edge N (1 cycle).
// Backpressure: ready is low only while a completed packet is held (HOLD); decoded from state only.
//
// Ports:
//   nocclk, rst_n           clock and asynchronous active-low reset
//   received_flit[_valid]   incoming flit and its valid
//   received_flit_ready     block can accept a flit this cycle
//   received_packet[_valid] registered assembled packet and its valid
//   received_packet_ack     consumer takes the held packet
//   received_flit_dropped   one-cycle pulse after any discard (flit or partial packet)

package types;
  typedef enum logic [1:0] {
    FLIT_HEAD = 2'd0,
    FLIT_BODY = 2'd1,
    FLIT_TAIL = 2'd2,
    FLIT_RSVD = 2'd3
  } flit_type_t;

  typedef struct packed {
    logic [7:0] packet_id;
    logic [3:0] flit_seq;
  } flit_id_t;

  typedef struct packed {
    flit_type_t flit_type;
    flit_id_t   flit_id;
  } header_t;

  typedef struct packed {
    header_t     header;
    logic [31:0] payload;
  } flit_t;
endpackage

package packet_types;
  localparam int BUFFER_LEN = 8;
  localparam int TAIL_W     = $clog2(BUFFER_LEN + 1);
  localparam int IDX_W      = $clog2(BUFFER_LEN);

  typedef struct packed {
    logic [7:0]                        packet_id;
    logic [TAIL_W-1:0]                 tail_index;
    logic                              is_complete;
    types::flit_t [BUFFER_LEN-1:0]     buffer;
  } packet_element_t;
endpackage

module packet_receive_buffer #(
  parameter int BUFFER_DEPTH = 8,
  parameter int TIMEOUT      = 64
) (
  input  logic                          nocclk,
  input  logic                          rst_n,
  input  types::flit_t                  received_flit,
  input  logic                          received_flit_valid,
  output logic                          received_flit_ready,
  output packet_types::packet_element_t received_packet,
  output logic                          received_packet_valid,
  input  logic                          received_packet_ack,
  output logic                          received_flit_dropped
);

  localparam int TW     = $clog2(TIMEOUT + 1);
  localparam int TAIL_W = packet_types::TAIL_W;
  localparam int IDX_W  = packet_types::IDX_W;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ASSEMBLE = 2'd1,
    S_HOLD     = 2'd2
  } state_t;

  state_t                        state_q, state_d;
  packet_types::packet_element_t packet_q, packet_d;
  logic [TW-1:0]                 timer_q, timer_d;
  logic                          dropped_q, dropped_d;

  logic                          flit_accept;
  logic [TW-1:0]                 timer_inc;
  logic                          buffer_full;
  logic                          id_match;
  logic [IDX_W-1:0]              wr_idx;
  logic                          start_head;
  types::flit_type_t             flit_type;

  assign received_flit_ready   = (state_q != S_HOLD);
  assign received_packet_valid = (state_q == S_HOLD);
  assign received_packet       = packet_q;
  assign received_flit_dropped = dropped_q;

  assign flit_accept = received_flit_valid & received_flit_ready;
  assign flit_type   = received_flit.header.flit_type;
  assign id_match    = (received_flit.header.flit_id.packet_id == packet_q.packet_id);
  assign buffer_full = (packet_q.tail_index == TAIL_W'(BUFFER_DEPTH));
  // Only used when the buffer is not full, so tail_index < BUFFER_DEPTH here.
  assign wr_idx      = packet_q.tail_index[IDX_W-1:0];
  // Saturating increment so a long stall can never wrap the idle timer.
  assign timer_inc   = (timer_q == '1) ? timer_q : timer_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    packet_d   = packet_q;
    timer_d    = timer_q;
    dropped_d  = 1'b0;
    start_head = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (flit_accept) begin
          if (flit_type == types::FLIT_HEAD) begin
            start_head = 1'b1;
          end else begin
            dropped_d = 1'b1;
          end
        end
      end

      S_ASSEMBLE: begin
        if (flit_accept) begin
          // Overflow takes precedence: whatever arrives at a full buffer kills the packet.
          if (buffer_full) begin
            dropped_d = 1'b1;
            packet_d  = '0;
            timer_d   = '0;
            state_d   = S_IDLE;
          end else if (flit_type == types::FLIT_HEAD) begin
            // Restart on a new HEAD regardless of its id; the partial packet is lost.
            dropped_d  = 1'b1;
            start_head = 1'b1;
          end else if (!id_match) begin
            // Stray flit from another packet: drop it, keep assembling ours.
            dropped_d = 1'b1;
          end else if (flit_type == types::FLIT_BODY) begin
            packet_d.buffer[wr_idx] = received_flit;
            packet_d.tail_index     = packet_q.tail_index + 1'b1;
            timer_d                 = '0;
          end else if (flit_type == types::FLIT_TAIL) begin
            packet_d.buffer[wr_idx] = received_flit;
            packet_d.tail_index     = packet_q.tail_index + 1'b1;
            packet_d.is_complete    = 1'b1;
            timer_d                 = '0;
            state_d                 = S_HOLD;
          end else begin
            dropped_d = 1'b1;
          end
        end else if (timer_inc >= TW'(TIMEOUT - 1)) begin
          // Timer would reach TIMEOUT-1 on this idle edge: give up on the packet.
          dropped_d = 1'b1;
          packet_d  = '0;
          timer_d   = '0;
          state_d   = S_IDLE;
        end else begin
          timer_d = timer_inc;
        end
      end

      S_HOLD: begin
        if (received_packet_ack) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (start_head) begin
      packet_d            = '0;
      packet_d.packet_id  = received_flit.header.flit_id.packet_id;
      packet_d.buffer[0]  = received_flit;
      packet_d.tail_index = TAIL_W'(1);
      timer_d             = '0;
      state_d             = S_ASSEMBLE;
    end
  end

  always_ff @(posedge nocclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      packet_q  <= '0;
      timer_q   <= '0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      packet_q  <= packet_d;
      timer_q   <= timer_d;
      dropped_q <= dropped_d;
    end
  end

endmodule

// File: tb/tb_packet_receive_buffer.sv
// Purpose : self-checking bench for packet_receive_buffer with an expected-packet scoreboard.
// Latency : outputs sampled 1 time unit after each rising nocclk edge.
// Backpressure: consumer ack driven explicitly by each scenario.

module tb_packet_receive_buffer;
  import types::*;
  import packet_types::*;

  logic            nocclk = 1'b0;
  logic            rst_n;
  flit_t           received_flit;
  logic            received_flit_valid;
  logic            received_flit_ready;
  packet_element_t received_packet;
  logic            received_packet_valid;
  logic            received_packet_ack;
  logic            received_flit_dropped;

  int checks   = 0;
  int failures = 0;

  packet_element_t exp_q[$];
  packet_element_t mdl;
  packet_element_t exp_pkt;

  always #5 nocclk = ~nocclk;

  packet_receive_buffer #(
    .BUFFER_DEPTH(8),
    .TIMEOUT     (64)
  ) dut (
    .nocclk               (nocclk),
    .rst_n                (rst_n),
    .received_flit        (received_flit),
    .received_flit_valid  (received_flit_valid),
    .received_flit_ready  (received_flit_ready),
    .received_packet      (received_packet),
    .received_packet_valid(received_packet_valid),
    .received_packet_ack  (received_packet_ack),
    .received_flit_dropped(received_flit_dropped)
  );

  task automatic step();
    @(posedge nocclk);
    #1;
  endtask

  // Drives one flit for one edge. When to_model is set the flit is part of a
  // packet expected to complete, and the expected packet is built and queued.
  task automatic send_flit(input flit_type_t t, input logic [7:0] id, input bit to_model);
    flit_t f;
    f.header.flit_type         = t;
    f.header.flit_id.packet_id = id;
    f.header.flit_id.flit_seq  = 4'($urandom);
    f.payload                  = $urandom;
    received_flit       = f;
    received_flit_valid = 1'b1;
    if (to_model) begin
      if (t == FLIT_HEAD) begin
        mdl            = '0;
        mdl.packet_id  = id;
        mdl.buffer[0]  = f;
        mdl.tail_index = 1;
      end else begin
        mdl.buffer[mdl.tail_index[2:0]] = f;
        mdl.tail_index = mdl.tail_index + 1'b1;
        if (t == FLIT_TAIL) begin
          mdl.is_complete = 1'b1;
          exp_q.push_back(mdl);
        end
      end
    end
    step();
    received_flit_valid = 1'b0;
    received_flit       = '0;
  endtask

  task automatic test_reset();
    rst_n               = 1'b0;
    received_flit       = '0;
    received_flit_valid = 1'b0;
    received_packet_ack = 1'b0;
    #3;
    checks++;
    if ({received_flit_ready, received_packet_valid, received_flit_dropped} !== 3'b100) begin
      failures++;
      $display("FAIL reset_outputs: ready/valid/dropped=%b want 100",
               {received_flit_ready, received_packet_valid, received_flit_dropped});
    end
    checks++;
    if (received_packet !== '0) begin
      failures++;
      $display("FAIL reset_packet: got %h want 0", received_packet);
    end
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({received_flit_ready, received_packet_valid, received_flit_dropped} !== 3'b100) begin
        failures++;
        $display("FAIL idle_after_reset[%0d]: ready/valid/dropped=%b want 100", i,
                 {received_flit_ready, received_packet_valid, received_flit_dropped});
      end
    end
  endtask

  task automatic test_basic_packet();
    send_flit(FLIT_HEAD, 8'd1, 1'b1);
    checks++;
    if ({received_flit_ready, received_packet_valid, received_flit_dropped} !== 3'b100) begin
      failures++;
      $display("FAIL basic_after_head: ready/valid/dropped=%b want 100",
               {received_flit_ready, received_packet_valid, received_flit_dropped});
    end
    send_flit(FLIT_BODY, 8'd1, 1'b1);
    send_flit(FLIT_TAIL, 8'd1, 1'b1);
    checks++;
    if ({received_flit_ready, received_packet_valid} !== 2'b01) begin
      failures++;
      $display("FAIL basic_valid_after_tail: ready/valid=%b want 01",
               {received_flit_ready, received_packet_valid});
    end
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL basic_scoreboard: queue empty, want 1 entry");
      exp_pkt = '0;
    end else begin
      exp_pkt = exp_q.pop_front();
      if (received_packet !== exp_pkt) begin
        failures++;
        $display("FAIL basic_packet: got %h want %h", received_packet, exp_pkt);
      end
    end
    checks++;
    if ({received_packet.tail_index, received_packet.packet_id, received_packet.is_complete}
        !== {4'd3, 8'd1, 1'b1}) begin
      failures++;
      $display("FAIL basic_fields: tail=%0d id=%0d complete=%0b want 3 1 1",
               received_packet.tail_index, received_packet.packet_id, received_packet.is_complete);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (received_flit_ready !== 1'b0 || received_packet_valid !== 1'b1 ||
          received_packet !== exp_pkt) begin
        failures++;
        $display("FAIL basic_hold[%0d]: ready=%b valid=%b packet=%h want 0 1 %h", i,
                 received_flit_ready, received_packet_valid, received_packet, exp_pkt);
      end
    end
    received_packet_ack = 1'b1;
    step();
    received_packet_ack = 1'b0;
    checks++;
    if ({received_flit_ready, received_packet_valid} !== 2'b10) begin
      failures++;
      $display("FAIL basic_after_ack: ready/valid=%b want 10",
               {received_flit_ready, received_packet_valid});
    end
  endtask

  task automatic test_stray_and_mismatch();
    received_packet_ack = 1'b1;
    step();
    received_packet_ack = 1'b0;
    checks++;
    if ({received_flit_ready, received_packet_valid, received_flit_dropped} !== 3'b100) begin
      failures++;
      $display("FAIL ack_while_idle: ready/valid/dropped=%b want 100",
               {received_flit_ready, received_packet_valid, received_flit_dropped});
    end
    send_flit(FLIT_BODY, 8'd2, 1'b0);
    checks++;
    if ({received_packet_valid, received_flit_dropped} !== 2'b01) begin
      failures++;
      $display("FAIL stray_body_drop: valid/dropped=%b want 01",
               {received_packet_valid, received_flit_dropped});
    end
    step();
    checks++;
    if (received_flit_dropped !== 1'b0) begin
      failures++;
      $display("FAIL stray_pulse_width: dropped=%b want 0", received_flit_dropped);
    end
    send_flit(FLIT_HEAD, 8'd3, 1'b1);
    send_flit(FLIT_BODY, 8'd4, 1'b0);
    checks++;
    if (received_flit_dropped !== 1'b1) begin
      failures++;
      $display("FAIL mismatch_drop: dropped=%b want 1", received_flit_dropped);
    end
    send_flit(FLIT_TAIL, 8'd3, 1'b1);
    checks++;
    if ({received_packet_valid, received_flit_dropped} !== 2'b10) begin
      failures++;
      $display("FAIL mismatch_complete: valid/dropped=%b want 10",
               {received_packet_valid, received_flit_dropped});
    end
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL mismatch_scoreboard: queue empty, want 1 entry");
    end else begin
      exp_pkt = exp_q.pop_front();
      if (received_packet !== exp_pkt || received_packet.tail_index !== 4'd2) begin
        failures++;
        $display("FAIL mismatch_packet: got %h want %h (tail_index 2)", received_packet, exp_pkt);
      end
    end
    received_packet_ack = 1'b1;
    step();
    received_packet_ack = 1'b0;
  endtask

  task automatic test_timeout();
    int early;
    send_flit(FLIT_HEAD, 8'd5, 1'b0);
    early = 0;
    for (int k = 1; k <= 62; k++) begin
      step();
      if (received_flit_dropped !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin
      failures++;
      $display("FAIL timeout_early: dropped pulses in idle cycles 1..62=%0d want 0", early);
    end
    step();
    checks++;
    if ({received_flit_ready, received_packet_valid, received_flit_dropped} !== 3'b101) begin
      failures++;
      $display("FAIL timeout_drop: ready/valid/dropped=%b want 101",
               {received_flit_ready, received_packet_valid, received_flit_dropped});
    end
    step();
    checks++;
    if (received_flit_dropped !== 1'b0) begin
      failures++;
      $display("FAIL timeout_pulse_width: dropped=%b want 0", received_flit_dropped);
    end
    send_flit(FLIT_TAIL, 8'd5, 1'b0);
    checks++;
    if ({received_packet_valid, received_flit_dropped} !== 2'b01) begin
      failures++;
      $display("FAIL timeout_tail_after: valid/dropped=%b want 01",
               {received_packet_valid, received_flit_dropped});
    end
    step();
  endtask

  task automatic test_overflow();
    int bad;
    bad = 0;
    send_flit(FLIT_HEAD, 8'd6, 1'b0);
    for (int i = 0; i < 7; i++) begin
      send_flit(FLIT_BODY, 8'd6, 1'b0);
      if (received_flit_dropped !== 1'b0 || received_packet_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL overflow_fill: unexpected drop/valid cycles=%0d want 0", bad);
    end
    send_flit(FLIT_BODY, 8'd6, 1'b0);
    checks++;
    if ({received_flit_ready, received_packet_valid, received_flit_dropped} !== 3'b101) begin
      failures++;
      $display("FAIL overflow_drop: ready/valid/dropped=%b want 101",
               {received_flit_ready, received_packet_valid, received_flit_dropped});
    end
    send_flit(FLIT_TAIL, 8'd6, 1'b0);
    checks++;
    if ({received_packet_valid, received_flit_dropped} !== 2'b01) begin
      failures++;
      $display("FAIL overflow_idle_after: valid/dropped=%b want 01",
               {received_packet_valid, received_flit_dropped});
    end
    step();
  endtask

  task automatic test_back_to_back();
    send_flit(FLIT_HEAD, 8'd8, 1'b0);
    send_flit(FLIT_HEAD, 8'd9, 1'b1);
    checks++;
    if (received_flit_dropped !== 1'b1) begin
      failures++;
      $display("FAIL restart_drop: dropped=%b want 1", received_flit_dropped);
    end
    send_flit(FLIT_BODY, 8'd9, 1'b1);
    checks++;
    if (received_flit_dropped !== 1'b0) begin
      failures++;
      $display("FAIL restart_single_pulse: dropped=%b want 0", received_flit_dropped);
    end
    send_flit(FLIT_TAIL, 8'd9, 1'b1);
    checks++;
    if (exp_q.size() == 0 || received_packet_valid !== 1'b1) begin
      failures++;
      $display("FAIL restart_scoreboard: valid=%b queued=%0d want 1 1",
               received_packet_valid, exp_q.size());
    end else begin
      exp_pkt = exp_q.pop_front();
      if (received_packet !== exp_pkt) begin
        failures++;
        $display("FAIL restart_packet: got %h want %h", received_packet, exp_pkt);
      end
    end
    // Ack in the first HOLD cycle, next HEAD on the very next edge.
    received_packet_ack = 1'b1;
    step();
    received_packet_ack = 1'b0;
    checks++;
    if ({received_flit_ready, received_packet_valid} !== 2'b10) begin
      failures++;
      $display("FAIL b2b_ack: ready/valid=%b want 10", {received_flit_ready, received_packet_valid});
    end
    send_flit(FLIT_HEAD, 8'd12, 1'b1);
    send_flit(FLIT_TAIL, 8'd12, 1'b1);
    checks++;
    if (exp_q.size() == 0 || received_packet_valid !== 1'b1) begin
      failures++;
      $display("FAIL b2b_scoreboard: valid=%b queued=%0d want 1 1",
               received_packet_valid, exp_q.size());
    end else begin
      exp_pkt = exp_q.pop_front();
      if (received_packet !== exp_pkt) begin
        failures++;
        $display("FAIL b2b_packet: got %h want %h", received_packet, exp_pkt);
      end
    end
    received_packet_ack = 1'b1;
    step();
    received_packet_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    send_flit(FLIT_HEAD, 8'd10, 1'b0);
    send_flit(FLIT_BODY, 8'd10, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({received_flit_ready, received_packet_valid, received_flit_dropped} !== 3'b100 ||
        received_packet !== '0) begin
      failures++;
      $display("FAIL reset_mid: ready/valid/dropped=%b packet=%h want 100 and 0",
               {received_flit_ready, received_packet_valid, received_flit_dropped}, received_packet);
    end
    #2;
    rst_n = 1'b1;
    step();
    checks++;
    if ({received_flit_ready, received_flit_dropped} !== 2'b10) begin
      failures++;
      $display("FAIL reset_mid_release: ready/dropped=%b want 10",
               {received_flit_ready, received_flit_dropped});
    end
    send_flit(FLIT_HEAD, 8'd11, 1'b1);
    send_flit(FLIT_BODY, 8'd11, 1'b1);
    send_flit(FLIT_TAIL, 8'd11, 1'b1);
    checks++;
    if (exp_q.size() == 0 || received_packet_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_scoreboard: valid=%b queued=%0d want 1 1",
               received_packet_valid, exp_q.size());
    end else begin
      exp_pkt = exp_q.pop_front();
      if (received_packet !== exp_pkt) begin
        failures++;
        $display("FAIL reset_mid_packet: got %h want %h", received_packet, exp_pkt);
      end
    end
    received_packet_ack = 1'b1;
    step();
    received_packet_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_packet();
    test_stray_and_mismatch();
    test_timeout();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d packets never delivered, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
